// File: rtl/dmem_responder_if.sv
// Request/response bundle between the EX/MEM stage and the data-memory responder.
// The master is the pipeline side; the slave is the memory responder.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        done;
  logic [31:0] rd_data;
  logic        err;

  modport master (
    output mem_read, mem_write, func3, addr, wr_data,
    input  stall, done, rd_data, err
  );

  modport slave (
    input  mem_read, mem_write, func3, addr, wr_data,
    output stall, done, rd_data, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: performs byte/half/word loads and stores with a fixed
// multi-cycle latency, stalling the pipeline until the access completes.
module dmem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  dmem_responder_if.slave bus
);

  localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_isStore;
  logic        r_both;
  logic [2:0]  r_func3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic        w_req;
  logic        w_isStore;
  logic        w_both;
  logic [2:0]  w_func3;
  logic [ADDR_W+1:0] w_addr;
  logic [31:0] w_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_err;
  logic [31:0] w_ldata;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic        w_finish;
  logic        w_commit;
  logic        w_unused;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_unused = &{1'b0, bus.addr[31:ADDR_W+2]};

  // The access that finishes straight out of IDLE (LATENCY of 1) is decoded from
  // the live inputs; otherwise the values captured at acceptance are used.
  always_comb begin
    if (r_state == IDLE) begin
      w_isStore = bus.mem_write;
      w_both    = bus.mem_read & bus.mem_write;
      w_func3   = bus.func3;
      w_addr    = bus.addr[ADDR_W+1:0];
      w_wdata   = bus.wr_data;
    end else begin
      w_isStore = r_isStore;
      w_both    = r_both;
      w_func3   = r_func3;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
    end
  end

  assign w_idx    = w_addr[ADDR_W+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_half   = w_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_finish = ((r_state == IDLE) && w_req && (LAT == 1)) ||
                    ((r_state == BUSY) && (r_cnt == 16'd0));
  assign w_commit = w_finish && w_isStore && !w_err && rst_n;

  // Legality check: simultaneous read/write, misalignment, or an unknown size code.
  always_comb begin
    w_err = 1'b0;
    if (w_both) begin
      w_err = 1'b1;
    end else if (w_isStore) begin
      case (w_func3)
        3'b000:  w_err = 1'b0;
        3'b001:  w_err = w_addr[0];
        3'b010:  w_err = |w_addr[1:0];
        default: w_err = 1'b1;
      endcase
    end else begin
      case (w_func3)
        3'b000, 3'b100: w_err = 1'b0;
        3'b001, 3'b101: w_err = w_addr[0];
        3'b010:         w_err = |w_addr[1:0];
        default:        w_err = 1'b1;
      endcase
    end
  end

  // Lane extraction and sign/zero extension of the addressed load data.
  always_comb begin
    w_byte  = 8'h00;
    w_ldata = 32'h0;
    case (w_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    if (!w_isStore && !w_err) begin
      case (w_func3)
        3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
        3'b010:  w_ldata = w_word;
        3'b100:  w_ldata = {24'h0, w_byte};
        3'b101:  w_ldata = {16'h0, w_half};
        default: w_ldata = 32'h0;
      endcase
    end
  end

  // Store data replicated across lanes, with byte enables picking the target lanes.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_wdata;
    case (w_func3)
      3'b000: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      3'b001: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      3'b010: begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
      end
      default: w_be = 4'b0000;
    endcase
  end

  // Memory array is never cleared; a store lands on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  // Access sequencer with registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 16'd0;
      r_isStore <= 1'b0;
      r_both    <= 1'b0;
      r_func3   <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
      if (w_finish) begin
        r_done  <= 1'b1;
        r_err   <= w_err;
        r_rdata <= w_ldata;
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_isStore <= bus.mem_write;
            r_both    <= bus.mem_read & bus.mem_write;
            r_func3   <= bus.func3;
            r_addr    <= bus.addr[ADDR_W+1:0];
            r_wdata   <= bus.wr_data;
            if (LAT == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= 16'(LAT - 2);
            end
          end
        end
        BUSY: begin
          if (r_cnt == 16'd0) r_state <= DONE;
          else                r_cnt   <= r_cnt - 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall   = ((r_state == IDLE) && w_req) || (r_state == BUSY);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at LATENCY=1.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.ADDR_W(9), .LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  dmem_responder #(.ADDR_W(9), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus2.mem_read = 1'b0; bus2.mem_write = 1'b0; bus2.func3 = 3'b000;
    bus2.addr = 32'h0; bus2.wr_data = 32'h0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.func3 = 3'b000;
    bus1.addr = 32'h0; bus1.wr_data = 32'h0;
  endtask

  // Issues one request, waits (bounded) for done and reports latency and stall cycles.
  task automatic applyStimulus(input bit useLat1, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rdata, output logic e,
                               output int lat, output int stallCnt);
    @(negedge clk);
    if (useLat1) begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.func3 = f3; bus1.addr = a; bus1.wr_data = d;
    end else begin
      bus2.mem_read = rd; bus2.mem_write = wr; bus2.func3 = f3; bus2.addr = a; bus2.wr_data = d;
    end
    #1;
    lat = 0;
    stallCnt = 0;
    while (((useLat1 ? bus1.done : bus2.done) !== 1'b1) && lat < 8) begin
      if ((useLat1 ? bus1.stall : bus2.stall) === 1'b1) stallCnt++;
      @(posedge clk);
      #1;
      clearInputs();
      lat++;
    end
    if ((useLat1 ? bus1.stall : bus2.stall) === 1'b1) stallCnt++;
    rdata = useLat1 ? bus1.rd_data : bus2.rd_data;
    e     = useLat1 ? bus1.err : bus2.err;
    @(posedge clk);
    #1;
  endtask

  task automatic runAccess(input string tag, input bit useLat1, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] expData, input logic expErr, input int expLat);
    logic [31:0] rdata;
    logic        e;
    int          lat;
    int          stallCnt;
    applyStimulus(useLat1, rd, wr, f3, a, d, rdata, e, lat, stallCnt);
    checkOutput({tag, " rd_data"}, rdata, expData);
    checkOutput({tag, " err"}, {31'h0, e}, {31'h0, expErr});
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " stall"}, stallCnt, expLat);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        e;
    int          lat;
    int          stallCnt;
    int          dones;
    int          stalls;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stall", {31'h0, bus2.stall}, 32'h0);
    checkOutput("reset done", {31'h0, bus2.done}, 32'h0);
    checkOutput("reset rd_data", bus2.rd_data, 32'h0);
    checkOutput("reset err", {31'h0, bus2.err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a word store is in flight: outputs clear at once, store is dropped.
    @(negedge clk);
    bus2.mem_write = 1'b1; bus2.func3 = 3'b010; bus2.addr = 32'h40; bus2.wr_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    clearInputs();
    checkOutput("abort busy stall", {31'h0, bus2.stall}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort stall", {31'h0, bus2.stall}, 32'h0);
    checkOutput("abort done", {31'h0, bus2.done}, 32'h0);
    checkOutput("abort rd_data", bus2.rd_data, 32'h0);
    checkOutput("abort err", {31'h0, bus2.err}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rdata, e, lat, stallCnt);
    checkOutput("abort store not committed", {31'h0, rdata !== 32'hDEADBEEF}, 32'h1);

    // Word store then load.
    runAccess("SW 40", 1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    runAccess("LW 40", 1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte/half sign and zero extension.
    runAccess("SW 10", 1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2);
    runAccess("LB 13", 1'b0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    runAccess("LBU 13", 1'b0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    runAccess("LH 12", 1'b0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    runAccess("LHU 10", 1'b0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2);
    runAccess("LB 10", 1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h00000001, 1'b0, 2);

    // Partial stores merge into the existing word; upper store-data bits are ignored.
    runAccess("SW 20", 1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2);
    runAccess("SB 21", 1'b0, 1'b0, 1'b1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 1'b0, 2);
    runAccess("SH 22", 1'b0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h5678BEEF, 32'h0, 1'b0, 2);
    runAccess("LW 20", 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0, 2);

    // Error cases: misalignment, illegal size codes, read+write together.
    runAccess("LW 42 misaligned", 1'b0, 1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 2);
    runAccess("SH 41 misaligned", 1'b0, 1'b0, 1'b1, 3'b001, 32'h41, 32'h1234, 32'h0, 1'b1, 2);
    runAccess("LW 40 after bad SH", 1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    runAccess("load f3 011", 1'b0, 1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 2);
    runAccess("store f3 011", 1'b0, 1'b0, 1'b1, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 2);
    runAccess("read+write", 1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1, 2);
    runAccess("LW 40 after errors", 1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Address wraps modulo the memory size.
    runAccess("SW 800 wrap", 1'b0, 1'b0, 1'b1, 3'b010, 32'h800, 32'h5, 32'h0, 1'b0, 2);
    runAccess("LW 0 wrap", 1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h5, 1'b0, 2);

    // Single-cycle latency instance.
    runAccess("L1 SW 4", 1'b1, 1'b0, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    runAccess("L1 LW 4", 1'b1, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0, 1);

    // Back-to-back loads held continuously: IDLE, DONE, IDLE, DONE ...
    @(negedge clk);
    bus1.mem_read = 1'b1; bus1.func3 = 3'b010; bus1.addr = 32'h4;
    #1;
    dones  = 0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus1.done === 1'b1) begin
        dones++;
        checkOutput("L1 b2b rd_data", bus1.rd_data, 32'hCAFEF00D);
      end
      if (bus1.stall === 1'b1) stalls++;
      @(posedge clk);
      #1;
    end
    clearInputs();
    checkOutput("L1 b2b done count", dones, 32'd4);
    checkOutput("L1 b2b stall count", stalls, 32'd4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
